// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM state
// encoding and the bit positions of the {Z,Neg,C,V} flag vector.
package alu_pkg;

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_PASSB = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOTA  = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  localparam int FLAG_Z   = 3;
  localparam int FLAG_NEG = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;

  // Opcodes 12..15 are reserved and produce an error result.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bus of the sequential ALU.
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds valid and its payload until that
// edge; ready may depend combinationally on the consumer's state but
// never on valid of the same channel.
interface seq_alu_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic [3:0]   flags;
  logic         err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, flags, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, flags, err
  );
endinterface

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier. The first partial product is folded
// in on the start edge, so done rises on the edge that performs the
// Nth iteration and product is valid combinationally alongside it.
module seq_mul #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N);

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;

  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(N - 1));

  // Operand load on start, then one shift-add step per cycle while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(1);
      acc    <= b[0] ? {{N{1'b0}}, a} : '0;
      mcand  <= {{(N-1){1'b0}}, a, 1'b0};
      mplier <= {1'b0, b[N-1:1]};
    end else if (busy) begin
      acc    <= product;
      mcand  <= {mcand[2*N-2:0], 1'b0};
      mplier <= {1'b0, mplier[N-1:1]};
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, N-cycle multiply
// through seq_mul, and a one-deep output register with backpressure.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus,
  output alu_state_t dbg_state
);
  localparam int SW = $clog2(N);

  alu_state_t     state, state_nxt;
  logic           in_ready;
  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [2*N-1:0] mul_product;
  logic [3:0]     mul_flags;

  logic           out_valid_q;
  logic [N-1:0]   out_q;
  logic [3:0]     flags_q;
  logic           err_q;

  logic [SW-1:0]  sh;
  logic [N:0]     wide;
  logic [N-1:0]   alu_res;
  logic           alu_c;
  logic           alu_v;
  logic           alu_err;
  logic [3:0]     alu_flags;

  // New work only in IDLE and only when the output slot is free or draining.
  assign in_ready      = !rst && (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flags     = flags_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;

  seq_mul #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath; shifts carry the last bit shifted out in an extra bit.
  always_comb begin
    sh      = bus.b[SW-1:0];
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = !op_legal(bus.op);
    case (bus.op)
      OP_PASSA: alu_res = bus.a;
      OP_PASSB: alu_res = bus.b;
      OP_ADD: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (bus.a[N-1] == bus.b[N-1]) && (alu_res[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        alu_res = bus.a - bus.b;
        alu_c   = bus.a < bus.b;
        alu_v   = (bus.a[N-1] != bus.b[N-1]) && (alu_res[N-1] != bus.a[N-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOTA: alu_res = ~bus.a;
      OP_SHL: begin
        wide    = {1'b0, bus.a} << sh;
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
      end
      OP_SHR: begin
        wide    = {bus.a, 1'b0} >> sh;
        alu_res = wide[N:1];
        alu_c   = wide[0];
      end
      OP_SRA: begin
        wide    = $signed({bus.a, 1'b0}) >>> sh;
        alu_res = wide[N:1];
        alu_c   = wide[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags = '0;
    if (!alu_err) begin
      alu_flags[FLAG_Z]   = (alu_res == '0);
      alu_flags[FLAG_NEG] = alu_res[N-1];
      alu_flags[FLAG_C]   = alu_c;
      alu_flags[FLAG_V]   = alu_v;
    end
  end

  // Multiply flags: V marks a product that does not fit in N bits.
  always_comb begin
    mul_flags           = '0;
    mul_flags[FLAG_Z]   = (mul_product[N-1:0] == '0);
    mul_flags[FLAG_NEG] = mul_product[N-1];
    mul_flags[FLAG_V]   = |mul_product[2*N-1:N];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and multiplier start.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && bus.op == OP_MUL) begin
          state_nxt = ST_MUL;
          mul_start = 1'b1;
        end
      end
      ST_MUL:  if (mul_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output register: load single-cycle or multiply results, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else if (accept && bus.op != OP_MUL) begin
      out_valid_q <= 1'b1;
      out_q       <= alu_res;
      flags_q     <= alu_flags;
      err_q       <= alu_err;
    end else if (state == ST_MUL && mul_done) begin
      out_valid_q <= 1'b1;
      out_q       <= mul_product[N-1:0];
      flags_q     <= mul_flags;
      err_q       <= 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at N=16: directed vector table, multi-cycle corner
// sequences, and randomized ops scored against an arithmetic model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int     N    = 16;
  localparam longint MOD  = 64'sd1 << N;
  localparam longint HALF = 64'sd1 << (N - 1);
  localparam int     NV   = 19;

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] out;
    logic [3:0]   flags;
    logic         err;
  } vec_t;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  alu_state_t dbg_state;
  always #5 clk = ~clk;

  seq_alu_if #(.N(N)) bus ();

  seq_alu #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int            checks   = 0;
  int            failures = 0;
  logic [N+4:0]  exp_q[$];
  vec_t          vecs[NV];
  int            lat;
  int            stall;
  logic          bad;
  logic [3:0]    r_op;
  logic [N-1:0]  r_a, r_b, xa, xb;
  logic [N+4:0]  got, expv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int guard;
    guard       = 0;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Latency counted in edges, the accepting edge being edge 1.
  task automatic wait_result(output int l);
    l = 1;
    while (!bus.out_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  // Reference model: plain integer arithmetic on the opcode rules. Returns {out, Z, Neg, C, V, err}.
  function automatic logic [N+4:0] model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    longint ua, ub, sa, sb, t;
    int sh;
    logic c, v;
    logic [N-1:0] r;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    sh = int'(ub % N);
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    case (op)
      4'd0: r = a;
      4'd1: r = b;
      4'd2: begin
        t = ua + ub; r = N'(t % MOD); c = (t >= MOD);
        t = sa + sb; v = (t >= HALF) || (t < -HALF);
      end
      4'd3: begin
        t = ua - ub; r = N'((t + MOD) % MOD); c = (ua < ub);
        t = sa - sb; v = (t >= HALF) || (t < -HALF);
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~a;
      4'd8: begin
        t = ua * (64'sd1 << sh); r = N'(t % MOD);
        c = (sh == 0) ? 1'b0 : (((t / MOD) % 2) == 1);
      end
      4'd9: begin
        r = N'(ua / (64'sd1 << sh));
        c = (sh == 0) ? 1'b0 : (((ua / (64'sd1 << (sh - 1))) % 2) == 1);
      end
      4'd10: begin
        r = N'(sa >>> sh);
        c = (sh == 0) ? 1'b0 : (((ua / (64'sd1 << (sh - 1))) % 2) == 1);
      end
      4'd11: begin
        t = ua * ub; r = N'(t % MOD); v = (t >= MOD);
      end
      default: return {{N{1'b0}}, 4'b0000, 1'b1};
    endcase
    return {r, (r == '0), r[N-1], c, v, 1'b0};
  endfunction

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    //            op        a         b         out       ZNCV     err
    vecs[0]  = '{OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0};
    vecs[1]  = '{OP_SUB,   16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1'b0};
    vecs[2]  = '{OP_SRA,   16'h8001, 16'h0001, 16'hC000, 4'b0110, 1'b0};
    vecs[3]  = '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0};
    vecs[4]  = '{4'd13,    16'hAAAA, 16'h5555, 16'h0000, 4'b0000, 1'b1};
    vecs[5]  = '{OP_PASSA, 16'h1234, 16'hFFFF, 16'h1234, 4'b0000, 1'b0};
    vecs[6]  = '{OP_PASSB, 16'h0000, 16'h8000, 16'h8000, 4'b0100, 1'b0};
    vecs[7]  = '{OP_SHL,   16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0};
    vecs[8]  = '{OP_SHR,   16'h0003, 16'h0011, 16'h0001, 4'b0010, 1'b0};
    vecs[9]  = '{OP_SHR,   16'h8000, 16'h0010, 16'h8000, 4'b0100, 1'b0};
    vecs[10] = '{OP_NOTA,  16'h0000, 16'h1234, 16'hFFFF, 4'b0100, 1'b0};
    vecs[11] = '{OP_AND,   16'hF0F0, 16'h0F0F, 16'h0000, 4'b1000, 1'b0};
    vecs[12] = '{OP_SUB,   16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0};
    vecs[13] = '{OP_MUL,   16'h0100, 16'h0100, 16'h0000, 4'b1001, 1'b0};
    vecs[14] = '{OP_MUL,   16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0};
    vecs[15] = '{OP_OR,    16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000, 1'b0};
    vecs[16] = '{OP_XOR,   16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b0};
    vecs[17] = '{4'd15,    16'h0001, 16'h0001, 16'h0000, 4'b0000, 1'b1};
    vecs[18] = '{OP_SHL,   16'h0003, 16'h000F, 16'h8000, 4'b0110, 1'b0};

    // reset state
    tick(); tick(); tick();
    check("rst_in_ready_low", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_state", dbg_state, ST_IDLE);

    // directed vector table
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result(lat);
      check($sformatf("vec%0d_lat", i), lat, (vecs[i].op == OP_MUL) ? 16 : 1);
      check($sformatf("vec%0d_out", i), bus.out, vecs[i].out);
      check($sformatf("vec%0d_flags", i), bus.flags, vecs[i].flags);
      check($sformatf("vec%0d_err", i), bus.err, vecs[i].err);
    end
    drain();

    // multiply with a competing request held during the busy period
    issue(OP_MUL, 16'h0100, 16'h0100);
    bus.in_valid = 1'b1;
    bus.op       = OP_PASSA;
    bus.a        = 16'hBEEF;
    bus.b        = 16'h0000;
    bad = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (bus.out_valid || bus.in_ready) bad = 1'b1;
      tick();
    end
    check("mul_busy_quiet", bad, 0);
    check("mul_valid_at_16", bus.out_valid, 1);
    check("mul_out", bus.out, 16'h0000);
    check("mul_flags", bus.flags, 4'b1001);
    tick();
    bus.in_valid = 1'b0;
    check("after_mul_passa", {bus.out_valid, bus.out}, {1'b1, 16'hBEEF});
    drain();

    // backpressure hold, then one result per cycle
    bus.out_ready = 1'b0;
    issue(OP_AND, 16'hFF0F, 16'h0FF3);
    bus.in_valid = 1'b1;
    bus.op       = OP_XOR;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    check("stall_first", {bus.out_valid, bus.out, bus.flags}, {1'b1, 16'h0F03, 4'b0000});
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.out !== 16'h0F03 || bus.flags !== 4'b0000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        bad = 1'b1;
    end
    check("stall_hold", bad, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      xa = N'($urandom);
      xb = N'($urandom);
      bus.a = xa;
      bus.b = xb;
      tick();
      check($sformatf("xor_stream%0d", k), {bus.out_valid, bus.out}, {1'b1, xa ^ xb});
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_clear", bus.out_valid, 0);
    drain();

    // reset in the middle of a multiply
    issue(OP_MUL, 16'h00FF, 16'h00FF);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_in_ready_low", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_in_ready_rel", bus.in_ready, 1);
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (bus.out_valid) bad = 1'b1;
    end
    check("abort_no_stale", bad, 0);
    issue(OP_MUL, 16'h0003, 16'h0007);
    wait_result(lat);
    check("post_abort_lat", lat, 16);
    check("post_abort_out", bus.out, 16'h0015);
    drain();

    // randomized ops against the model, with random backpressure
    for (int i = 0; i < 150; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = N'($urandom);
      r_b  = N'($urandom);
      if ($urandom_range(0, 3) == 0) r_b = N'($urandom_range(0, 2 * N - 1));
      if ($urandom_range(0, 5) == 0) r_a = (i % 2 == 0) ? 16'hFFFF : 16'h8000;
      exp_q.push_back(model(r_op, r_a, r_b));
      stall = $urandom_range(0, 2);
      bus.out_ready = (stall == 0);
      issue(r_op, r_a, r_b);
      wait_result(lat);
      check($sformatf("rand%0d_lat op=%0d", i, r_op), lat, (r_op == OP_MUL) ? 16 : 1);
      got  = {bus.out, bus.flags, bus.err};
      expv = exp_q.pop_front();
      check($sformatf("rand%0d_result op=%0d a=%0h b=%0h", i, r_op, r_a, r_b), got, expv);
      if (stall > 0) begin
        bad = 1'b0;
        repeat (stall) begin
          tick();
          if ({bus.out, bus.flags, bus.err} !== got || !bus.out_valid) bad = 1'b1;
        end
        check($sformatf("rand%0d_hold", i), bad, 0);
        bus.out_ready = 1'b1;
      end
      tick();
      check($sformatf("rand%0d_clear", i), bus.out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand/result width (N >= 4, power of two).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning operation request present.
REQ-005 SHALL have port in_ready, output, 1, meaning request accepted this cycle if in_valid is high.
REQ-006 SHALL have ports a and b, input, N each, meaning operands.
REQ-007 SHALL have port op, input, 4, meaning opcode.
REQ-008 SHALL have port out_valid, output, 1, meaning result present.
REQ-009 SHALL have port out_ready, input, 1, meaning consumer takes the result.
REQ-010 SHALL have port out, output, N, meaning result.
REQ-011 SHALL have port flags, output, 4, meaning {Z,Neg,C,V}.
REQ-012 SHALL have port err, output, 1, meaning illegal opcode accompanies the result.

Function
REQ-013 SHALL decode op as: 0 PASSA, 1 PASSB, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOTA, 8 SHL, 9 SHR logical, 10 SRA, 11 MUL unsigned low N bits, 12-15 illegal.
REQ-014 SHALL accept a request on any edge where in_valid and in_ready are both high, capturing a, b and op.
REQ-015 SHALL drive in_ready = (state==IDLE) and (!out_valid or out_ready).
REQ-016 SHALL, for every non-MUL op, present out/flags/err with out_valid high starting the edge after acceptance (latency 1).
REQ-017 SHALL use FSM states IDLE and MUL:
- IDLE -> MUL on acceptance of op 11.
- MUL performs one shift-add iteration per cycle for exactly N cycles.
- On the Nth iteration edge: load out, set out_valid, return to IDLE (latency N).
REQ-018 SHALL hold out, flags and err stable while out_valid is high and out_ready is low.
REQ-019 SHALL clear out_valid on an edge with out_ready high unless a new single-cycle result loads on that same edge; back-to-back throughput is then one op per cycle.
REQ-020 SHALL use shift amount b[log2(N)-1:0] for ops 8-10; upper b bits are ignored; amount 0 returns a unchanged.
REQ-021 SHALL compute flags:
- Z = (out==0).
- Neg = out[N-1].
- C: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR/SRA last bit shifted out, 0 if amount 0; 0 for all other ops.
- V: ADD/SUB signed overflow; MUL 1 if the 2N-bit product exceeds N bits; 0 for all other ops.
REQ-022 SHALL compute ADD/SUB modulo 2^N with wrap-around, e.g. N=16: 0xFFFF+1 = 0x0000 with C=1, Z=1.
REQ-023 SHALL, for ops 12-15, return out=0, flags=0000 and err=1 with latency 1; err SHALL be 0 for all legal ops.
REQ-024 SHALL ignore in_valid while in MUL state (in_ready is low).
REQ-025 SHALL never drive high-impedance on any output.

Reset
REQ-026 SHALL, on rst high at a clock edge, force state=IDLE, out_valid=0, out=0, flags=0, err=0 and the iteration counter to 0.
REQ-027 SHALL abort an in-progress MUL on reset with no result produced; rst dominates simultaneous in_valid or out_ready.
REQ-028 SHALL drive in_ready low while rst is high, and high on the first cycle after reset release.

Structure
REQ-029 SHALL place the opcode constants, the FSM state encoding and the flag bit indices in a shared package alu_pkg.
REQ-030 SHALL implement the iterative multiplier as one sub-module, seq_mul: parameter N; ports start, a, b, done, product[2N-1:0].

Verification (N=16)
REQ-031 SHALL cover: ADD a=0x7FFF b=0x0001 -> out=0x8000, flags Neg=1 V=1 C=0 Z=0, out_valid 1 cycle after accept.
REQ-032 SHALL cover: SUB a=0x0003 b=0x0005 -> out=0xFFFE, C=1 Neg=1; SRA a=0x8001 b=0x0001 -> out=0xC000, C=1.
REQ-033 SHALL cover: MUL a=0x0100 b=0x0100 -> out=0x0000, V=1, Z=1, out_valid exactly 16 cycles after accept, in_ready low throughout.
REQ-034 SHALL cover: out_ready held low 5 cycles with AND result pending -> out and flags stable, in_ready low; then out_ready high with new valid XOR request -> one result per cycle thereafter.
REQ-035 SHALL cover: rst asserted at MUL cycle 7 -> next edge out_valid=0, in_ready=1 after release, no stale result emitted.
REQ-036 SHALL cover: op=13 -> out=0x0000, err=1, flags=0000; a following PASSA a=0x1234 -> out=0x1234, err=0.
